// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage: datapath/register sizes,
// load funct3 encodings and the arbiter grant encoding.
package wb_stage_pkg;
  localparam int DataSize    = 32;
  localparam int RegAddrSize = 5;
  localparam int RegFileSize = 1 << RegAddrSize;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Which source won the most recent accept.
  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;
endpackage

// File: rtl/wb_stage_if.sv
// Writeback stage bus: ALU and load result handshakes, decoder issue and
// hazard query, and the register file write port.
// master = upstream pipeline / register file side, slave = wb_stage.
interface wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              aluValid;
  logic              aluReady;
  logic [ADDR_W-1:0] aluRd;
  logic [DATA_W-1:0] aluData;
  logic              memValid;
  logic              memReady;
  logic [ADDR_W-1:0] memRd;
  logic [DATA_W-1:0] memData;
  logic [2:0]        memFunct3;
  logic [1:0]        memByteOff;
  logic              issueValid;
  logic [ADDR_W-1:0] issueRd;
  logic              flush;
  logic [ADDR_W-1:0] rs1Addr;
  logic [ADDR_W-1:0] rs2Addr;
  logic              rs1Busy;
  logic              rs2Busy;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeDate;

  modport master (
    output aluValid, aluRd, aluData, memValid, memRd, memData, memFunct3,
           memByteOff, issueValid, issueRd, flush, rs1Addr, rs2Addr,
    input  aluReady, memReady, rs1Busy, rs2Busy, writeEnable, writeAddr,
           writeDate
  );
  modport slave (
    input  aluValid, aluRd, aluData, memValid, memRd, memData, memFunct3,
           memByteOff, issueValid, issueRd, flush, rs1Addr, rs2Addr,
    output aluReady, memReady, rs1Busy, rs2Busy, writeEnable, writeAddr,
           writeDate
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load alignment (combinational): selects the byte/half addressed by
// byte_off out of the aligned memory word and sign/zero extends it.
// Ports: mem_data/funct3/byte_off in, data_o formatted word out.
module wb_stage_load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = DataSize
) (
  input  logic [DATA_W-1:0] mem_data,
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = mem_data[{byte_off, 3'b000} +: 8];
    // Halfword loads ignore byte_off[0].
    half_v = mem_data[{byte_off[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      F3_LH:   data_o = {{(DATA_W-16){half_v[15]}}, half_v};
      F3_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_v};
      F3_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_v};
      default: data_o = mem_data;  // LW and undefined codes
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: round-robin arbiter between ALU and load results,
// registered register-file write port, and pending-destination scoreboard
// for RAW hazard stalls.
// Ports: clk, rst_n (async active low), bus (wb_stage_if.slave).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = DataSize,
  parameter int ADDR_W = RegAddrSize
) (
  input logic    clk,
  input logic    rst_n,
  wb_stage_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  grant_e            last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic              alu_acc, mem_acc, acc;
  logic [ADDR_W-1:0] acc_rd;
  logic [DATA_W-1:0] acc_data, mem_fmt;

  wb_stage_load_align #(.DATA_W(DATA_W)) u_load_align (
    .mem_data (bus.memData),
    .funct3   (bus.memFunct3),
    .byte_off (bus.memByteOff),
    .data_o   (mem_fmt)
  );

  // Under contention the source not granted last time wins.
  always_comb begin
    alu_acc  = bus.aluValid && (!bus.memValid || last_grant_q == GRANT_MEM);
    mem_acc  = bus.memValid && (!bus.aluValid || last_grant_q == GRANT_ALU);
    acc      = alu_acc || mem_acc;
    acc_rd   = alu_acc ? bus.aluRd : bus.memRd;
    acc_data = alu_acc ? bus.aluData : mem_fmt;
  end

  assign bus.aluReady    = alu_acc;
  assign bus.memReady    = mem_acc;
  assign bus.writeEnable = we_q;
  assign bus.writeAddr   = waddr_q;
  assign bus.writeDate   = wdata_q;
  assign bus.rs1Busy     = (bus.rs1Addr != '0) && pending_q[bus.rs1Addr];
  assign bus.rs2Busy     = (bus.rs2Addr != '0) && pending_q[bus.rs2Addr];

  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_acc)      last_grant_d = GRANT_ALU;
    else if (mem_acc) last_grant_d = GRANT_MEM;

    // x0 results are consumed but never written; addr/data hold otherwise.
    we_d    = acc && (acc_rd != '0);
    waddr_d = we_d ? acc_rd : waddr_q;
    wdata_d = we_d ? acc_data : wdata_q;

    // Order matters: flush, then retire-clear, then issue-set, so a newer
    // producer issued this cycle survives both.
    pending_d = bus.flush ? '0 : pending_q;
    if (acc) pending_d[acc_rd] = 1'b0;
    if (bus.issueValid && bus.issueRd != '0) pending_d[bus.issueRd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_MEM;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      pending_q    <= pending_d;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t q[$];
  int vectors = 0;
  int errs = 0;
  bit mlast = 1'b1;          // 1 = MEM granted last
  logic [31:0] mem_exp;      // expected formatted load for the current step

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    bus.aluValid = 0; bus.memValid = 0; bus.issueValid = 0; bus.flush = 0;
  endtask

  // Check readies, push expected writes, step one clock, check write port.
  task automatic cycle(input string tag);
    bit ea, em;
    wr_t w;
    #1;
    ea = bus.aluValid && (!bus.memValid || mlast);
    em = bus.memValid && (!bus.aluValid || !mlast);
    chk({tag, ".aluReady"}, 32'(bus.aluReady), 32'(ea));
    chk({tag, ".memReady"}, 32'(bus.memReady), 32'(em));
    if (ea) begin
      mlast = 0;
      if (bus.aluRd != 0) q.push_back('{bus.aluRd, bus.aluData});
    end
    if (em) begin
      mlast = 1;
      if (bus.memRd != 0) q.push_back('{bus.memRd, mem_exp});
    end
    @(posedge clk); #1;
    chk({tag, ".we"}, 32'(bus.writeEnable), 32'(q.size() != 0));
    if (q.size() != 0) begin
      w = q.pop_front();
      chk({tag, ".waddr"}, 32'(bus.writeAddr), 32'(w.a));
      chk({tag, ".wdata"}, bus.writeDate, w.d);
    end
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] off,
                      input logic [4:0] rd, input logic [31:0] expv, input string tag);
    idle();
    bus.memValid = 1; bus.memRd = rd; bus.memData = 32'h80F77F01;
    bus.memFunct3 = f3; bus.memByteOff = off; mem_exp = expv;
    cycle(tag);
  endtask

  initial begin
    idle();
    bus.aluRd = 0; bus.aluData = 0; bus.memRd = 0; bus.memData = 0;
    bus.memFunct3 = 3'b010; bus.memByteOff = 0; bus.issueRd = 0;
    bus.rs1Addr = 0; bus.rs2Addr = 0; mem_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.we", 32'(bus.writeEnable), 0);
    chk("rst.waddr", 32'(bus.writeAddr), 0);
    chk("rst.wdata", bus.writeDate, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Single ALU write, then a bubble.
    bus.aluValid = 1; bus.aluRd = 5; bus.aluData = 32'h1234;
    cycle("alu1");
    idle();
    cycle("idle1");

    // Contention: grants alternate every cycle.
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.aluValid = 1; bus.aluRd = 1; bus.aluData = 32'h0000_0111;
      bus.memValid = 1; bus.memRd = 2; bus.memData = 32'hDEADBEEF;
      bus.memFunct3 = 3'b010; bus.memByteOff = 0; mem_exp = 32'hDEADBEEF;
      cycle("rr");
    end

    // Load formatting, back to back.
    load(3'b000, 2'd3, 5'd10, 32'hFFFFFF80, "lb3");
    load(3'b100, 2'd3, 5'd11, 32'h00000080, "lbu3");
    load(3'b001, 2'd2, 5'd12, 32'hFFFF80F7, "lh2");
    load(3'b101, 2'd0, 5'd13, 32'h00007F01, "lhu0");
    load(3'b011, 2'd1, 5'd14, 32'h80F77F01, "f3_011");
    load(3'b001, 2'd3, 5'd15, 32'hFFFF80F7, "lh3");

    // Scoreboard: issue, clear on accept, same-cycle set wins.
    idle(); bus.issueValid = 1; bus.issueRd = 7; bus.rs1Addr = 7;
    cycle("iss7");
    idle(); #1;
    chk("busy7.set", 32'(bus.rs1Busy), 1);
    bus.aluValid = 1; bus.aluRd = 7; bus.aluData = 32'hCAFE0007; #1;
    chk("busy7.acc_cycle", 32'(bus.rs1Busy), 1);
    cycle("ret7");
    idle(); #1;
    chk("busy7.cleared", 32'(bus.rs1Busy), 0);
    bus.issueValid = 1; bus.issueRd = 7;
    cycle("iss7b");
    idle();
    bus.aluValid = 1; bus.aluRd = 7; bus.aluData = 32'h77;
    bus.issueValid = 1; bus.issueRd = 7;
    cycle("ret_iss7");
    idle(); #1;
    chk("busy7.set_wins", 32'(bus.rs1Busy), 1);

    // x0: accepted, not written, never pending.
    bus.aluValid = 1; bus.aluRd = 0; bus.aluData = 32'hFFFF;
    cycle("x0_alu");
    idle(); bus.issueValid = 1; bus.issueRd = 0; bus.rs1Addr = 0;
    cycle("x0_iss");
    idle(); #1;
    chk("busy0", 32'(bus.rs1Busy), 0);

    // Flush clears everything; issue alongside flush survives.
    bus.issueValid = 1; bus.issueRd = 3;
    cycle("iss3");
    idle(); bus.issueValid = 1; bus.issueRd = 9;
    cycle("iss9");
    idle(); bus.rs1Addr = 3; bus.rs2Addr = 9; #1;
    chk("busy3", 32'(bus.rs1Busy), 1);
    chk("busy9", 32'(bus.rs2Busy), 1);
    bus.flush = 1; bus.issueValid = 1; bus.issueRd = 4;
    cycle("flush");
    idle(); #1;
    chk("flush.busy3", 32'(bus.rs1Busy), 0);
    chk("flush.busy9", 32'(bus.rs2Busy), 0);
    bus.rs1Addr = 7; bus.rs2Addr = 4; #1;
    chk("flush.busy7", 32'(bus.rs1Busy), 0);
    chk("flush.iss4", 32'(bus.rs2Busy), 1);

    // Reset during a write cycle.
    bus.issueValid = 1; bus.issueRd = 8;
    cycle("iss8");
    idle(); bus.aluValid = 1; bus.aluRd = 6; bus.aluData = 32'h600D;
    cycle("pre_rst");   // writeEnable is high now
    idle();
    rst_n = 0; #1;
    chk("midrst.we", 32'(bus.writeEnable), 0);
    chk("midrst.waddr", 32'(bus.writeAddr), 0);
    chk("midrst.wdata", bus.writeDate, 0);
    bus.rs1Addr = 8; #1;
    chk("midrst.busy8", 32'(bus.rs1Busy), 0);
    chk("midrst.busy4", 32'(bus.rs2Busy), 0);
    @(posedge clk); #1;
    rst_n = 1; mlast = 1;
    // After reset the ALU wins the first contention.
    bus.aluValid = 1; bus.aluRd = 1; bus.aluData = 32'hA1;
    bus.memValid = 1; bus.memRd = 2; bus.memFunct3 = 3'b010;
    bus.memData = 32'h5; mem_exp = 32'h5;
    cycle("post_rst");
    idle();
    cycle("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
